alu_wide_seq: RTL and testbench

//  Multi-cycle sequencer that runs 16-bit ops on the shared 8-bit combinational alu.

---
 rtl/alu_wide_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_wide_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// Multi-cycle sequencer that runs 16-bit ADD/SUB/shift/compare ops on a shared
// 8-bit combinational alu, one byte slice per cycle, chaining sc bits between slices.
module alu_wide_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic        shift_in,
    output logic [3:0]  alu_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_sc_i,
    input  logic [7:0]  alu_rslt,
    input  logic        alu_sc_o,
    input  logic        alu_cnd,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic        cnd_out,
    output logic        err
);

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0001;
    localparam logic [3:0] CMD_CMP = 4'b0100;
    localparam logic [3:0] CMD_CEQ = 4'b0101;
    localparam logic [3:0] CMD_LSL = 4'b0110;
    localparam logic [3:0] CMD_LSR = 4'b0111;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_LSL = 3'd2;
    localparam logic [2:0] OP_LSR = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_1    = 3'd1;
    localparam logic [2:0] S_2    = 3'd2;
    localparam logic [2:0] S_3    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [2:0]    r_op;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic          r_shin;
    logic [BW-1:0] r_byte;   // first-slice result byte
    logic          r_sc;     // first-slice sc_o
    logic          r_f1;     // first-slice cnd (gt_h for CMP, eq_h for EQ)
    logic          r_f2;     // second-slice cnd (eq_h for CMP)
    logic          w_accept;
    logic          w_illegal;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_illegal = (op == 3'd6) || (op == 3'd7);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_illegal ? S_DONE : S_1;
            S_1:     w_next = S_2;
            S_2:     w_next = (r_op == OP_CMP) ? S_3 : S_DONE;
            S_3:     w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Alu slice drive: byte order and sc chaining depend on op and step
    always_comb begin
        alu_cmd  = CMD_ADD;
        alu_a    = '0;
        alu_b    = '0;
        alu_sc_i = 1'b0;
        case (r_state)
            S_1: begin
                case (r_op)
                    OP_ADD: begin alu_cmd = CMD_ADD; alu_a = r_a[7:0];  alu_b = r_b[7:0]; end
                    OP_SUB: begin alu_cmd = CMD_SUB; alu_a = r_a[7:0];  alu_b = r_b[7:0]; end
                    OP_LSL: begin alu_cmd = CMD_LSL; alu_b = r_b[7:0];  alu_sc_i = r_shin; end
                    OP_LSR: begin alu_cmd = CMD_LSR; alu_b = r_b[15:8]; alu_sc_i = r_shin; end
                    OP_CMP: begin alu_cmd = CMD_CMP; alu_a = r_a[15:8]; alu_b = r_b[15:8]; end
                    OP_EQ:  begin alu_cmd = CMD_CEQ; alu_a = r_a[15:8]; alu_b = r_b[15:8]; end
                    default: ;
                endcase
            end
            S_2: begin
                case (r_op)
                    OP_ADD: begin alu_cmd = CMD_ADD; alu_a = r_a[15:8]; alu_b = r_b[15:8]; alu_sc_i = r_sc; end
                    OP_SUB: begin alu_cmd = CMD_SUB; alu_a = r_a[15:8]; alu_b = r_b[15:8]; alu_sc_i = ~r_sc; end
                    OP_LSL: begin alu_cmd = CMD_LSL; alu_b = r_b[15:8]; alu_sc_i = r_sc; end
                    OP_LSR: begin alu_cmd = CMD_LSR; alu_b = r_b[7:0];  alu_sc_i = r_sc; end
                    OP_CMP: begin alu_cmd = CMD_CEQ; alu_a = r_a[15:8]; alu_b = r_b[15:8]; end
                    OP_EQ:  begin alu_cmd = CMD_CEQ; alu_a = r_a[7:0];  alu_b = r_b[7:0]; end
                    default: ;
                endcase
            end
            S_3: begin
                alu_cmd = CMD_CMP;
                alu_a   = r_a[7:0];
                alu_b   = r_b[7:0];
            end
            default: ;
        endcase
    end

    // Operand latches, slice capture and registered results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_shin    <= 1'b0;
            r_byte    <= '0;
            r_sc      <= 1'b0;
            r_f1      <= 1'b0;
            r_f2      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            cnd_out   <= 1'b0;
            err       <= 1'b0;
        end else begin
            busy <= (w_next != S_IDLE);
            done <= (w_next == S_DONE);
            if (w_accept) begin
                r_op   <= op;
                r_a    <= opA;
                r_b    <= opB;
                r_shin <= shift_in;
                if (w_illegal) begin
                    result    <= '0;
                    carry_out <= 1'b0;
                    cnd_out   <= 1'b0;
                    err       <= 1'b1;
                end
            end
            case (r_state)
                S_1: begin
                    r_byte <= alu_rslt;
                    r_sc   <= alu_sc_o;
                    r_f1   <= alu_cnd;
                end
                S_2: begin
                    r_f2 <= alu_cnd;
                    err  <= 1'b0;
                    case (r_op)
                        OP_ADD, OP_SUB, OP_LSL: begin
                            result    <= {alu_rslt, r_byte};
                            carry_out <= alu_sc_o;
                            cnd_out   <= 1'b0;
                        end
                        OP_LSR: begin
                            result    <= {r_byte, alu_rslt};
                            carry_out <= alu_sc_o;
                            cnd_out   <= 1'b0;
                        end
                        OP_EQ: begin
                            result    <= '0;
                            carry_out <= 1'b0;
                            cnd_out   <= r_f1 & alu_cnd;
                        end
                        default: ;
                    endcase
                end
                S_3: begin
                    result    <= '0;
                    carry_out <= 1'b0;
                    cnd_out   <= r_f1 | (r_f2 & alu_cnd);
                    err       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: behavioural 8-bit alu, 16-bit reference model and
// an expected-result queue popped at each done pulse.
module tb_alu_wide_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] opA, opB;
    logic        shift_in;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_a, alu_b;
    logic        alu_sc_i;
    logic [7:0]  alu_rslt;
    logic        alu_sc_o;
    logic        alu_cnd;
    logic        busy, done, carry_out, cnd_out, err;
    logic [15:0] result;

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        cnd;
        logic        err;
        logic [3:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_wide_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .shift_in(shift_in), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
        .alu_cnd(alu_cnd), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .cnd_out(cnd_out), .err(err)
    );

    // Behavioural 8-bit alu
    always_comb begin
        logic [8:0] t;
        t        = '0;
        alu_rslt = '0;
        alu_sc_o = 1'b0;
        alu_cnd  = 1'b0;
        case (alu_cmd)
            4'b0000: begin t = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_sc_i); alu_rslt = t[7:0]; alu_sc_o = t[8]; end
            4'b0001: begin t = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_sc_i); alu_rslt = t[7:0]; alu_sc_o = ~t[8]; end
            4'b0100: alu_cnd = (alu_a > alu_b);
            4'b0101: alu_cnd = (alu_a == alu_b);
            4'b0110: {alu_sc_o, alu_rslt} = {alu_b, alu_sc_i};
            4'b0111: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_b};
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                   input logic sh);
        exp_t e;
        logic [16:0] s;
        e = '0;
        e.lat = 4'd3;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[15:0]; e.cy = s[16]; end
            3'd1: begin e.res = a - b; e.cy = (a >= b); end
            3'd2: {e.cy, e.res} = {b, sh};
            3'd3: {e.res, e.cy} = {sh, b};
            3'd4: begin e.cnd = (a > b); e.lat = 4'd4; end
            3'd5: e.cnd = (a == b);
            default: begin e.err = 1'b1; e.lat = 4'd1; end
        endcase
        return e;
    endfunction

    // Issue one request; optionally pulse a second start while busy
    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic sh, input bit poke);
        exp_t e;
        int   lat;
        int   extra;
        sb.push_back(model(o, a, b, sh));
        @(negedge clk);
        start = 1'b1; op = o; opA = a; opB = b; shift_in = sh;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (poke && c == 1) begin
                check("busy_after_accept", 32'(busy), 32'd1);
                start = 1'b1; op = 3'd0; opA = 16'h5555; opB = 16'h1111; shift_in = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) lat = c;
        end
        start = 1'b0;
        e = sb.pop_front();
        if (lat == 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(e.lat));
            check("result", 32'(result), 32'(e.res));
            check("carry_out", 32'(carry_out), 32'(e.cy));
            check("cnd_out", 32'(cnd_out), 32'(e.cnd));
            check("err", 32'(err), 32'(e.err));
            check("busy_in_done", 32'(busy), 32'd1);
        end
        if (poke) begin
            extra = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("poke_no_extra_done", 32'(extra), 32'd0);
            check("poke_result_held", 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        int extra;
        reset = 1'b1; start = 1'b0; op = '0; opA = '0; opB = '0; shift_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry_out, cnd_out, err}), 32'd0);
        check("rst_alu_cmd", 32'({alu_cmd, alu_a, alu_b, alu_sc_i}), 32'd0);
        reset = 1'b0;

        run_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(3'd1, 16'h0100, 16'h0001, 1'b0, 1'b0);
        run_op(3'd1, 16'h0000, 16'h0001, 1'b0, 1'b0);
        run_op(3'd2, 16'h0000, 16'h8080, 1'b1, 1'b0);
        run_op(3'd3, 16'h0000, 16'h0101, 1'b0, 1'b0);
        run_op(3'd4, 16'h1280, 16'h127F, 1'b0, 1'b0);
        run_op(3'd4, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
        run_op(3'd4, 16'h1200, 16'h1300, 1'b0, 1'b0);
        run_op(3'd5, 16'hABCD, 16'hABCD, 1'b0, 1'b0);
        run_op(3'd5, 16'hABCD, 16'hABCC, 1'b0, 1'b0);
        run_op(3'd7, 16'h1234, 16'h5678, 1'b1, 1'b0);
        run_op(3'd6, 16'h1234, 16'h5678, 1'b1, 1'b0);
        @(negedge clk);
        check("idle_alu_cmd", 32'({alu_cmd, alu_a, alu_b, alu_sc_i}), 32'd0);

        run_op(3'd0, 16'h1234, 16'h4321, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++)
            run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

        // Abort in S2: outputs clear at once, no done afterwards
        run_op(3'd0, 16'h7000, 16'h0123, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; opA = 16'h1111; opB = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        extra = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort_no_done", 32'(extra), 32'd0);

        run_op(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        run_op(3'd4, 16'h0001, 16'h0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
